// File: rtl/receive.sv
// rtl/receive.sv - UART receiver, 8N1 with mid-bit sampling and stb/rdy byte handshake.
// Optional even-parity bit before the stop bit when PARITY_EN is defined.
module receive #(
    parameter real BAUDRATE  = 96e2,
    parameter real FREQUENCY = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       stb,
    output logic [7:0] dat,
    input  logic       rdy,
    output logic       err,
    output logic       ovr
);

    localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
    localparam int HALF   = CYCLES / 2;
    localparam int CW     = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rxs;
`ifdef PARITY_EN
    logic          par_err;
`endif

    // Presetting to 1 keeps an idle line from looking like a start bit after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            stb     <= 1'b0;
            dat     <= 8'h00;
            err     <= 1'b0;
            ovr     <= 1'b0;
`ifdef PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            ovr <= 1'b0;
            if (stb && rdy)
                stb <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (!rxs)
                        state <= START;
                end

                // Half-bit check filters glitches and aligns later samples to mid-bit.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_err <= rxs ^ (^shreg);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // Leaving at mid-stop gives half a bit to catch a back-to-back start.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            err   <= 1'b1;
                            state <= BRK;
                        end
`ifdef PARITY_EN
                        else if (par_err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
`endif
                        else begin
                            state <= IDLE;
                            if (!stb || rdy) begin
                                dat <= shreg;
                                stb <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BRK: begin
                    cnt <= '0;
                    if (rxs)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
